// File: rtl/quad_paddle_bank.sv
// PLAYERS-channel quadrature paddle decoder: sync, debounce, Gray decode, clamped position.
// Build option QUAD_X4_EN: defined = step on every Gray transition (x4), undefined = step on entering 00 (x1).
module quad_paddle_bank #(
  parameter int unsigned PLAYERS   = 2,
  parameter int unsigned POS_WIDTH = 5,
  parameter int unsigned POS_MAX   = 27,
  parameter int unsigned POS_INIT  = 13,
  parameter int unsigned DEBOUNCE  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PLAYERS-1:0]             enc_a,
  input  logic [PLAYERS-1:0]             enc_b,
  input  logic                           center,
  output logic [PLAYERS*POS_WIDTH-1:0]   position,
  output logic [PLAYERS-1:0]             moved,
  output logic [PLAYERS-1:0]             dir,
  output logic [PLAYERS-1:0]             qerr
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  function automatic logic [1:0] gray_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  for (genvar g = 0; g < PLAYERS; g++) begin : g_ch
    logic [1:0]           s1_q, s2_q, last_q, filt_q, filt_d;
    logic [CW-1:0]        cnt_q, cnt_d, base;
    logic                 accept, fwd, rev, illegal;
    logic                 up_q, up_d, dn_q, dn_d, qerr_q, qerr_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 moved_q, moved_d, dir_q, dir_d;

    always_comb begin
      filt_d  = filt_q;
      cnt_d   = '0;
      accept  = 1'b0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      qerr_d  = 1'b0;
      // A change of the synchronised pair restarts the count even if it never matched filt.
      base    = (s2_q != last_q) ? '0 : cnt_q;
      if (s2_q != filt_q) begin
        if (base == CW'(DEBOUNCE - 1)) begin
          accept = 1'b1;
          filt_d = s2_q;
        end else begin
          cnt_d = base + 1'b1;
        end
      end

      fwd     = (gray_next(filt_q) == s2_q);
      rev     = (gray_next(s2_q) == filt_q);
      illegal = ((filt_q ^ s2_q) == 2'b11);
      if (accept) begin
        qerr_d = illegal;
`ifdef QUAD_X4_EN
        up_d = fwd;
        dn_d = rev;
`else
        up_d = fwd && (s2_q == 2'b00);
        dn_d = rev && (s2_q == 2'b00);
`endif
      end

      pos_d   = pos_q;
      moved_d = 1'b0;
      dir_d   = dir_q;
      if (center) begin
        pos_d = POS_WIDTH'(POS_INIT);
      end else if (up_q) begin
        dir_d = 1'b1;
        if (pos_q != POS_WIDTH'(POS_MAX)) begin
          pos_d   = pos_q + 1'b1;
          moved_d = 1'b1;
        end
      end else if (dn_q) begin
        dir_d = 1'b0;
        if (pos_q != '0) begin
          pos_d   = pos_q - 1'b1;
          moved_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q    <= '0;
        s2_q    <= '0;
        last_q  <= '0;
        filt_q  <= '0;
        cnt_q   <= '0;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
        qerr_q  <= 1'b0;
        pos_q   <= POS_WIDTH'(POS_INIT);
        moved_q <= 1'b0;
        dir_q   <= 1'b0;
      end else begin
        s1_q    <= {enc_a[g], enc_b[g]};
        s2_q    <= s1_q;
        last_q  <= s2_q;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
        up_q    <= up_d;
        dn_q    <= dn_d;
        qerr_q  <= qerr_d;
        pos_q   <= pos_d;
        moved_q <= moved_d;
        dir_q   <= dir_d;
      end
    end

    assign position[g*POS_WIDTH +: POS_WIDTH] = pos_q;
    assign moved[g] = moved_q;
    assign dir[g]   = dir_q;
    assign qerr[g]  = qerr_q;
  end

endmodule
